// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the IF stage: owns the PC, decodes flow-control ops,
// takes interrupts and drives the return-address stack with a local depth mirror.
module pc_sequencer #(
    parameter int                      PC_WIDTH     = 13,
    parameter int                      DEPTH        = 8,
    parameter logic [PC_WIDTH-1:0]     RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0]     INT_VECTOR   = PC_WIDTH'(4)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                instr_valid,
    input  logic [2:0]          op,
    input  logic [PC_WIDTH-1:0] target,
    input  logic                irq,
    input  logic [PC_WIDTH-1:0] stack_out,
    input  logic                stack_fault,
    output logic                push,
    output logic                pop,
    output logic [PC_WIDTH-1:0] push_pc,
    output logic [PC_WIDTH-1:0] pc,
    output logic                pc_valid,
    output logic                gie,
    output logic                fault,
    output logic [1:0]          stateDbg
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    localparam logic [2:0] OP_GOTO   = 3'b001;
    localparam logic [2:0] OP_CALL   = 3'b010;
    localparam logic [2:0] OP_RETURN = 3'b011;
    localparam logic [2:0] OP_RETFIE = 3'b100;

    typedef enum logic [1:0] {RUN = 2'd0, POP_WAIT = 2'd1, FAULT = 2'd2} stateT;

    stateT               state, stateNext;
    logic [PC_WIDTH-1:0] pcNext, pcPlusOne;
    logic [DW-1:0]       depth, depthNext;
    logic                gieNext;

    assign pcPlusOne = pc + PC_WIDTH'(1);
    assign pc_valid  = (state == RUN);
    assign fault     = (state == FAULT);
    assign stateDbg  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_VECTOR;
            depth <= '0;
            gie   <= 1'b1;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
            depth <= depthNext;
            gie   <= gieNext;
        end
    end

    // Stack handshake: push/pop are single-cycle strobes the stack samples on the
    // same edge; there is no ready, so the depth mirror refuses any access that
    // would over/underflow. stack_out is taken on the edge leaving POP_WAIT.
    always_comb begin
        stateNext = state;
        pcNext    = pc;
        depthNext = depth;
        gieNext   = gie;
        push      = 1'b0;
        pop       = 1'b0;
        push_pc   = '0;
        case (state)
            RUN: begin
                if (stack_fault) begin
                    stateNext = FAULT;
                end else if (!stall) begin
                    if (irq && gie) begin
                        // Interrupt behaves as a CALL that re-fetches the current pc on return.
                        if (depth == FULL) begin
                            stateNext = FAULT;
                        end else begin
                            push      = 1'b1;
                            push_pc   = pc;
                            pcNext    = INT_VECTOR;
                            depthNext = depth + DW'(1);
                            gieNext   = 1'b0;
                        end
                    end else if (instr_valid) begin
                        case (op)
                            OP_GOTO: pcNext = target;
                            OP_CALL: begin
                                if (depth == FULL) begin
                                    stateNext = FAULT;
                                end else begin
                                    push      = 1'b1;
                                    push_pc   = pcPlusOne;
                                    pcNext    = target;
                                    depthNext = depth + DW'(1);
                                end
                            end
                            OP_RETURN, OP_RETFIE: begin
                                if (depth == '0) begin
                                    stateNext = FAULT;
                                end else begin
                                    pop       = 1'b1;
                                    depthNext = depth - DW'(1);
                                    stateNext = POP_WAIT;
                                    if (op == OP_RETFIE) gieNext = 1'b1;
                                end
                            end
                            default: pcNext = pcPlusOne;
                        endcase
                    end
                end
            end
            POP_WAIT: begin
                if (stack_fault) begin
                    stateNext = FAULT;
                end else begin
                    pcNext    = stack_out;
                    stateNext = RUN;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the driver pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_pc_sequencer;

    localparam int PW = 13;
    localparam logic [2:0] SEQ = 3'd0, GOTO = 3'd1, CALL = 3'd2, RET = 3'd3, RETFIE = 3'd4;

    logic          clk = 1'b0;
    logic          reset, stall, instr_valid, irq, stack_fault;
    logic [2:0]    op;
    logic [PW-1:0] target, stack_out;
    logic          push, pop, pc_valid, gie, fault;
    logic [PW-1:0] push_pc, pc;
    logic [1:0]    stateDbg;

    // {push, pop, push_pc, pc, pc_valid, gie, fault}
    localparam int EW = 2 + 2 * PW + 3;
    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            compared = 0;
    int            mismatched = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .instr_valid(instr_valid), .op(op),
        .target(target), .irq(irq), .stack_out(stack_out), .stack_fault(stack_fault),
        .push(push), .pop(pop), .push_pc(push_pc), .pc(pc), .pc_valid(pc_valid),
        .gie(gie), .fault(fault), .stateDbg(stateDbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {push, pop, push_pc, pc, pc_valid, gie, fault};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL %s: got push=%b pop=%b push_pc=%h pc=%h pc_valid=%b gie=%b fault=%b, want push=%b pop=%b push_pc=%h pc=%h pc_valid=%b gie=%b fault=%b",
                         nm, a[EW-1], a[EW-2], a[EW-3 -: PW], a[PW+2:3], a[2], a[1], a[0],
                         e[EW-1], e[EW-2], e[EW-3 -: PW], e[PW+2:3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic cyc(input string nm, input logic rst, stl, irqI, sf, iv,
                       input logic [2:0] o, input logic [PW-1:0] tg, so,
                       input logic ePush, ePop, input logic [PW-1:0] ePushPc, ePc,
                       input logic eValid, eGie, eFault);
        reset = rst; stall = stl; irq = irqI; stack_fault = sf;
        instr_valid = iv; op = o; target = tg; stack_out = so;
        exp_q.push_back({ePush, ePop, ePushPc, ePc, eValid, eGie, eFault});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] cpc;
        int drain;
        reset = 1'b1; stall = 1'b0; irq = 1'b0; stack_fault = 1'b0;
        instr_valid = 1'b0; op = SEQ; target = '0; stack_out = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset state, sequential fetch and wrap
        cyc("reset_seq0", 0,0,0,0,1, SEQ, 0, 0,      0,0,0, 13'h0000, 1,1,0);
        cyc("seq1",       0,0,0,0,1, SEQ, 0, 0,      0,0,0, 13'h0001, 1,1,0);
        cyc("seq2",       0,0,0,0,1, SEQ, 0, 0,      0,0,0, 13'h0002, 1,1,0);
        cyc("seq3_idle",  0,0,0,0,0, SEQ, 0, 0,      0,0,0, 13'h0003, 1,1,0);
        cyc("goto_max",   0,0,0,0,1, GOTO, 13'h1FFF, 0, 0,0,0, 13'h0003, 1,1,0);
        cyc("seq_wrap",   0,0,0,0,1, SEQ, 0, 0,      0,0,0, 13'h1FFF, 1,1,0);
        cyc("wrapped",    0,0,0,0,0, SEQ, 0, 0,      0,0,0, 13'h0000, 1,1,0);

        // call / return
        cyc("goto_010",   0,0,0,0,1, GOTO, 13'h010, 0, 0,0,0, 13'h0000, 1,1,0);
        cyc("call_100",   0,0,0,0,1, CALL, 13'h100, 0, 1,0,13'h011, 13'h0010, 1,1,0);
        cyc("return",     0,0,0,0,1, RET,  0, 0,      0,1,0, 13'h0100, 1,1,0);
        cyc("pop_wait",   0,0,0,0,0, SEQ,  0, 13'h011, 0,0,0, 13'h0100, 0,1,0);
        cyc("returned",   0,0,0,0,0, SEQ,  0, 0,      0,0,0, 13'h0011, 1,1,0);

        // interrupt drops a concurrent GOTO, RETFIE restores gie
        cyc("goto_020",   0,0,0,0,1, GOTO, 13'h020, 0, 0,0,0, 13'h0011, 1,1,0);
        cyc("irq_take",   0,0,1,0,1, GOTO, 13'h300, 0, 1,0,13'h020, 13'h0020, 1,1,0);
        cyc("isr_retfie", 0,0,0,0,1, RETFIE, 0, 0,    0,1,0, 13'h0004, 1,0,0);
        cyc("retfie_pw",  0,0,0,0,0, SEQ, 0, 13'h020, 0,0,0, 13'h0004, 0,1,0);
        cyc("irq_ret",    0,0,0,0,0, SEQ, 0, 0,       0,0,0, 13'h0020, 1,1,0);

        // stall blocks a CALL; irq during POP_WAIT is deferred
        cyc("stall_call", 0,1,0,0,1, CALL, 13'h200, 0, 0,0,0, 13'h0020, 1,1,0);
        cyc("call_200",   0,0,0,0,1, CALL, 13'h200, 0, 1,0,13'h021, 13'h0020, 1,1,0);
        cyc("return2",    0,0,0,0,1, RET,  0, 0,       0,1,0, 13'h0200, 1,1,0);
        cyc("pw_irq",     0,1,1,0,1, CALL, 13'h555, 13'h021, 0,0,0, 13'h0200, 0,1,0);
        cyc("irq_after",  0,0,1,0,1, SEQ,  0, 0,       1,0,13'h021, 13'h0021, 1,1,0);
        cyc("retfie2",    0,0,0,0,1, RETFIE, 0, 0,     0,1,0, 13'h0004, 1,0,0);
        cyc("retfie2_pw", 0,0,0,0,0, SEQ, 0, 13'h021,  0,0,0, 13'h0004, 0,1,0);

        // reset during POP_WAIT
        cyc("call_300",   0,0,0,0,1, CALL, 13'h300, 0, 1,0,13'h022, 13'h0021, 1,1,0);
        cyc("return3",    0,0,0,0,1, RET,  0, 0,       0,1,0, 13'h0300, 1,1,0);
        cyc("pw_reset",   1,0,0,0,0, SEQ,  0, 13'h022, 0,0,0, 13'h0300, 0,1,0);
        cyc("after_rst",  0,0,0,0,0, SEQ,  0, 0,       0,0,0, 13'h0000, 1,1,0);

        // underflow: RETURN at depth 0 (depth cleared by reset)
        cyc("ret_empty",  0,0,0,0,1, RET,  0, 0,       0,0,0, 13'h0000, 1,1,0);
        cyc("uflow_flt",  0,0,0,0,1, SEQ,  0, 0,       0,0,0, 13'h0000, 0,1,1);
        cyc("flt_rst",    1,0,0,0,0, SEQ,  0, 0,       0,0,0, 13'h0000, 0,1,1);

        // stack_fault pulse in RUN
        cyc("sf_pulse",   0,0,0,1,1, SEQ,  0, 0,       0,0,0, 13'h0000, 1,1,0);
        cyc("sf_fault",   0,0,0,0,1, SEQ,  0, 0,       0,0,0, 13'h0000, 0,1,1);
        cyc("sf_rst",     1,0,0,0,0, SEQ,  0, 0,       0,0,0, 13'h0000, 0,1,1);

        // 8 nested calls fill the stack, the 9th overflows
        cpc = 13'h0000;
        for (int i = 0; i < 8; i++) begin
            logic [PW-1:0] tg;
            tg = 13'h100 + PW'(i * 16);
            cyc("nest_call", 0,0,0,0,1, CALL, tg, 0, 1,0, cpc + 13'h1, cpc, 1,1,0);
            cpc = tg;
        end
        cyc("call9",      0,0,0,0,1, CALL, 13'h500, 0, 0,0,0, 13'h0170, 1,1,0);
        cyc("oflow_flt",  0,0,0,0,1, SEQ,  0, 0,       0,0,0, 13'h0170, 0,1,1);
        cyc("oflow_hold", 0,0,1,0,1, GOTO, 13'h0AA, 0, 0,0,0, 13'h0170, 0,1,1);
        cyc("oflow_rst",  1,0,0,0,0, SEQ,  0, 0,       0,0,0, 13'h0170, 0,1,1);
        cyc("final_run",  0,0,0,0,0, SEQ,  0, 0,       0,0,0, 13'h0000, 1,1,0);

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending checks, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
